// File: rtl/aes_round_sched_if.sv
// ---------------------------------------------------------------------------
// aes_round_sched_if
// Block-level handshake bundle between the AES round scheduler and its
// producer/consumer.
//   in_valid  : new plaintext/key present at the datapath inputs
//   in_ready  : scheduler can accept a block
//   out_valid : ciphertext valid at the datapath output
//   out_ready : consumer takes the ciphertext
//   abort     : synchronous cancel of the block in flight
// The master modport is the producer/consumer side; the slave modport is
// the scheduler.
// ---------------------------------------------------------------------------
interface aes_round_sched_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic abort;

  modport master (output in_valid, output out_ready, output abort,
                  input  in_ready, input  out_valid);
  modport slave  (input  in_valid, input  out_ready, input  abort,
                  output in_ready, output out_valid);
endinterface

// File: rtl/aes_round_sched.sv
// ---------------------------------------------------------------------------
// aes_round_sched
// Control for an iterative AES-128 encryption datapath with on-the-fly key
// expansion. One block per handshake: LOAD (state=pt^key), NR-1 full rounds,
// then a final round without MixColumns. Produces the round constant and the
// per-cycle datapath / key-schedule enables. Control only: state and key
// registers, S-box and MixColumns live in the datapath.
//
// Parameters:
//   NR            number of rounds, 2..10 (below 10 only for reduced builds)
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   hs            handshake bundle (in_valid/in_ready/out_valid/out_ready/abort)
//   dp_load       datapath loads state=pt^key, key reg=key
//   dp_round_en   datapath executes one round this cycle
//   dp_last_round current round skips MixColumns
//   ks_step       key schedule advances one round key
//   rcon          round constant consumed with ks_step
//   round_idx     current round number (0 during load)
//   sbox_sel      shared S-box owner: 1 = key schedule, 0 = datapath
//   busy          scheduler is not idle
//
// Build option AES_SBOX_SHARED_EN: the datapath and key schedule share one
// S-box bank, so every round takes two cycles, a key-schedule phase
// (sbox_sel=1, ks_step=1) followed by a datapath phase (dp_round_en=1).
// Without it, sbox_sel is tied low and ks_step coincides with dp_round_en.
//
// All outputs come straight from flops: the output decode runs on the
// next-state values and is registered together with the state.
// ---------------------------------------------------------------------------
module aes_round_sched #(
  parameter int NR = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  aes_round_sched_if.slave hs,
  output logic             dp_load,
  output logic             dp_round_en,
  output logic             dp_last_round,
  output logic             ks_step,
  output logic [7:0]       rcon,
  output logic [3:0]       round_idx,
  output logic             sbox_sel,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_e;

  // Registered output image; round_idx doubles as the round counter.
  typedef struct packed {
    logic       in_ready;
    logic       out_valid;
    logic       dp_load;
    logic       dp_round_en;
    logic       dp_last_round;
    logic       ks_step;
    logic       sbox_sel;
    logic       busy;
    logic [7:0] rcon;
    logic [3:0] round_idx;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{
    in_ready:      1'b1,
    out_valid:     1'b0,
    dp_load:       1'b0,
    dp_round_en:   1'b0,
    dp_last_round: 1'b0,
    ks_step:       1'b0,
    sbox_sel:      1'b0,
    busy:          1'b0,
    rcon:          8'h01,
    round_idx:     4'd0
  };

  // Round after which the last full round hands over to FINAL.
  localparam logic [3:0] LAST_FULL = 4'(NR - 1);

  state_e     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [3:0] rnd_d;
  logic       round_end;  // this cycle completes the current round
  logic       in_rnd;     // next state executes a round (ROUND or FINAL)

  // GF(2^8) doubling: successive round constants 01,02,...,80,1B,36.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

`ifdef AES_SBOX_SHARED_EN
  // 0 = key-schedule phase, 1 = datapath phase of the current round.
  logic phase_q, phase_d;

  // A round only ends on its datapath phase.
  assign round_end = phase_q;

  // The key-schedule phase always hands over to the datapath phase of the
  // same round; every other transition (new round, FINAL, abort) restarts
  // at the key-schedule phase.
  assign phase_d = !hs.abort && !phase_q &&
                   (state_q == ROUND || state_q == FINAL);
`else
  assign round_end = 1'b1;
`endif

  // -------------------------------------------------------------------------
  // State register (state, phase and the registered output image)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ctrl_q  <= CTRL_RST;
`ifdef AES_SBOX_SHARED_EN
      phase_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
`ifdef AES_SBOX_SHARED_EN
      phase_q <= phase_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rnd_d   = ctrl_q.round_idx;
    if (hs.abort) begin
      // Abort beats every other event, including an accept in IDLE and the
      // output handshake in DONE.
      state_d = IDLE;
      rnd_d   = 4'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone accepts.
          if (hs.in_valid) begin
            state_d = LOAD;
            rnd_d   = 4'd0;
          end
        end
        LOAD: begin
          // NR >= 2, so there is always at least one full round.
          state_d = ROUND;
          rnd_d   = 4'd1;
        end
        ROUND: begin
          if (round_end) begin
            if (ctrl_q.round_idx == LAST_FULL) state_d = FINAL;
            rnd_d = ctrl_q.round_idx + 4'd1;
          end
        end
        FINAL: begin
          if (round_end) state_d = DONE;
        end
        DONE: begin
          // No accept in the handshake cycle: IDLE (in_ready=1) follows.
          if (hs.out_ready) begin
            state_d = IDLE;
            rnd_d   = 4'd0;
          end
        end
        default: begin
          state_d = IDLE;
          rnd_d   = 4'd0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output decode on the next state; registered in the state register.
  // -------------------------------------------------------------------------
  assign in_rnd = (state_d == ROUND) || (state_d == FINAL);

  always_comb begin
    ctrl_d           = '0;
    ctrl_d.round_idx = rnd_d;
    ctrl_d.in_ready  = (state_d == IDLE);
    ctrl_d.busy      = (state_d != IDLE);
    ctrl_d.dp_load   = (state_d == LOAD);
    ctrl_d.out_valid = (state_d == DONE);
`ifdef AES_SBOX_SHARED_EN
    ctrl_d.ks_step       = in_rnd && !phase_d;
    ctrl_d.sbox_sel      = in_rnd && !phase_d;
    ctrl_d.dp_round_en   = in_rnd &&  phase_d;
    ctrl_d.dp_last_round = (state_d == FINAL) && phase_d;
`else
    ctrl_d.ks_step       = in_rnd;
    ctrl_d.sbox_sel      = 1'b0;
    ctrl_d.dp_round_en   = in_rnd;
    ctrl_d.dp_last_round = (state_d == FINAL);
`endif
    // rcon restarts at 01 whenever no block is in progress, and moves on
    // only after a cycle that actually stepped the key schedule.
    if (state_d == IDLE || state_d == LOAD) ctrl_d.rcon = 8'h01;
    else if (ctrl_q.ks_step)                ctrl_d.rcon = xtime(ctrl_q.rcon);
    else                                    ctrl_d.rcon = ctrl_q.rcon;
  end

  // -------------------------------------------------------------------------
  // Output wiring
  // -------------------------------------------------------------------------
  assign hs.in_ready    = ctrl_q.in_ready;
  assign hs.out_valid   = ctrl_q.out_valid;
  assign dp_load        = ctrl_q.dp_load;
  assign dp_round_en    = ctrl_q.dp_round_en;
  assign dp_last_round  = ctrl_q.dp_last_round;
  assign ks_step        = ctrl_q.ks_step;
  assign sbox_sel       = ctrl_q.sbox_sel;
  assign busy           = ctrl_q.busy;
  assign rcon           = ctrl_q.rcon;
  assign round_idx      = ctrl_q.round_idx;

endmodule

// File: tb/tb_aes_round_sched.sv
// ---------------------------------------------------------------------------
// tb_aes_round_sched
// Scoreboard bench for aes_round_sched (NR=10). The stimulus process pushes
// the hand-derived expected output image for every cycle it drives; a
// separate monitor pops one entry per cycle on the falling edge and compares.
// Output transfers are counted by the monitor and checked at the end.
// Works for the default build and for AES_SBOX_SHARED_EN.
// ---------------------------------------------------------------------------
module tb_aes_round_sched;
  localparam int NR = 10;

  bit          clk;
  logic        rst_n;
  logic        dp_load, dp_round_en, dp_last_round, ks_step, sbox_sel, busy;
  logic [7:0]  rcon;
  logic [3:0]  round_idx;

  aes_round_sched_if hs();

  aes_round_sched #(.NR(NR)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hs            (hs),
    .dp_load       (dp_load),
    .dp_round_en   (dp_round_en),
    .dp_last_round (dp_last_round),
    .ks_step       (ks_step),
    .rcon          (rcon),
    .round_idx     (round_idx),
    .sbox_sel      (sbox_sel),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // flg = {in_ready,out_valid,dp_load,dp_round_en,dp_last_round,ks_step,sbox_sel,busy}
  typedef struct {
    logic [7:0] flg;
    logic [7:0] rcon;
    logic [3:0] ridx;
    bit         rc_chk;
    bit         ri_chk;
  } exp_t;

  exp_t       exp_q[$];
  int         total, bad, xfers, exp_xfers;
  logic [7:0] rc_tab [0:9];

  function automatic exp_t mk(input logic [7:0] f, input logic [7:0] rc,
                              input int ri, input bit rck, input bit rik);
    exp_t e;
    e.flg = f; e.rcon = rc; e.ridx = 4'(ri); e.rc_chk = rck; e.ri_chk = rik;
    return e;
  endfunction

  function automatic exp_t e_idle(); return mk(8'b1000_0000, 8'h01, 0, 1'b1, 1'b1); endfunction
  function automatic exp_t e_load(); return mk(8'b0010_0001, 8'h01, 0, 1'b1, 1'b1); endfunction
  function automatic exp_t e_done(); return mk(8'b0100_0001, 8'h00, 0, 1'b0, 1'b0); endfunction
  // Single-cycle round r: datapath and key schedule together.
  function automatic exp_t e_rnd(input int r);
    return mk({3'b000, 1'b1, (r == NR), 1'b1, 1'b0, 1'b1}, rc_tab[r-1], r, 1'b1, 1'b1);
  endfunction
  // Shared S-box: key-schedule phase, then datapath phase of round r.
  function automatic exp_t e_ks(input int r);
    return mk(8'b0000_0111, rc_tab[r-1], r, 1'b1, 1'b1);
  endfunction
  function automatic exp_t e_dp(input int r);
    return mk({3'b000, 1'b1, (r == NR), 3'b001}, 8'h00, r, 1'b0, 1'b1);
  endfunction

  // One cycle of stimulus: drive inputs just after the rising edge and queue
  // what the registered outputs must show during this cycle.
  task automatic step(input logic iv, input logic ordy, input logic ab, input exp_t e);
    hs.in_valid  = iv;
    hs.out_ready = ordy;
    hs.abort     = ab;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // One block from accept onward. abort_r / rst_r select the round in which
  // abort or a reset pulse cuts the block short (0 = never).
  task automatic run_block(input int hold, input int abort_r, input int rst_r,
                           input bit ab_done, input logic ordy_bg);
    step(1'b1, ordy_bg, 1'b0, e_idle());
    step(1'b0, ordy_bg, 1'b0, e_load());
    for (int r = 1; r <= NR; r++) begin
      if (r == rst_r) begin
        rst_n = 1'b0;
        step(1'b0, ordy_bg, 1'b0, e_idle());
        step(1'b0, ordy_bg, 1'b0, e_idle());
        rst_n = 1'b1;
        return;
      end
`ifdef AES_SBOX_SHARED_EN
      step(1'b0, ordy_bg, (r == abort_r), e_ks(r));
      if (r == abort_r) return;
      step(1'b0, ordy_bg, 1'b0, e_dp(r));
`else
      step(1'b0, ordy_bg, (r == abort_r), e_rnd(r));
      if (r == abort_r) return;
`endif
    end
    // in_valid high while busy and in the handshake cycle must not accept.
    for (int h = 0; h < hold; h++) step(1'b1, 1'b0, 1'b0, e_done());
    step(1'b1, 1'b1, ab_done, e_done());
    if (!ab_done) exp_xfers++;
    step(1'b0, 1'b0, 1'b0, e_idle());
  endtask

  // Monitor: one comparison per cycle on the falling edge.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {hs.in_ready, hs.out_valid, dp_load, dp_round_en, dp_last_round,
               ks_step, sbox_sel, busy};
        total++;
        if (act !== e.flg || (e.rc_chk && rcon !== e.rcon) ||
            (e.ri_chk && round_idx !== e.ridx)) begin
          bad++;
          $display("FAIL ctrl t=%0t got flags=%b rcon=%h ridx=%0d want flags=%b rcon=%h(chk=%0d) ridx=%0d(chk=%0d)",
                   $time, act, rcon, round_idx, e.flg, e.rcon, e.rc_chk, e.ridx, e.ri_chk);
        end
      end
      if (rst_n && hs.out_valid && hs.out_ready && !hs.abort) xfers++;
    end
  end

  initial begin
    rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    rst_n = 1'b0;
    hs.in_valid = 1'b0; hs.out_ready = 1'b0; hs.abort = 1'b0;
    @(posedge clk);
    #1;
    // Reset held for 3 cycles, then 20 quiet idle cycles.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, e_idle());
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, e_idle());

    // Plain block, out_ready held high throughout.
    run_block(0, 0, 0, 1'b0, 1'b1);
    // Backpressure: out_ready low for 7 cycles after out_valid.
    run_block(7, 0, 0, 1'b0, 1'b0);
    // Abort in round 4, then a clean block right behind it.
    run_block(0, 4, 0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, e_idle());
    run_block(0, 0, 0, 1'b0, 1'b1);
    // abort together with in_valid in IDLE: no load follows.
    step(1'b1, 1'b0, 1'b1, e_idle());
    step(1'b0, 1'b0, 1'b0, e_idle());
    step(1'b0, 1'b0, 1'b0, e_idle());
    // abort together with out_ready in DONE: no transfer.
    run_block(2, 0, 0, 1'b1, 1'b0);
    // Reset pulse in round 6, then recovery with a full block.
    run_block(0, 0, 6, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, e_idle());
    run_block(0, 0, 0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, e_idle());

    total++;
    if (xfers != exp_xfers) begin
      bad++;
      $display("FAIL xfer_count got=%0d want=%0d", xfers, exp_xfers);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
